// File: rtl/core_pkg.sv
// Shared core parameters and the register-read stage payload type.
package core_pkg;

  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned PREG_W    = $clog2(NUM_PREGS);
  localparam int unsigned ROB_IDX_W = 5;
  localparam int unsigned UOP_W     = 32;
  localparam int unsigned XLEN      = 32;

  // p0 is the architectural zero register; it always reads as 0
  localparam logic [PREG_W-1:0] PREG_ZERO = '0;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [UOP_W-1:0]     uop;
    logic [PREG_W-1:0]    dest_preg;
  } rr_payload_t;

endpackage

// File: rtl/RegReadPhysRegFileIF.sv
// Read-port bundle between the register-read stage and the physical register file.
interface RegReadPhysRegFileIF;
  import core_pkg::*;

  logic [PREG_W-1:0] src1_index;
  logic [PREG_W-1:0] src2_index;
  logic [XLEN-1:0]   src1_val;
  logic [XLEN-1:0]   src2_val;

  modport RegRead     (output src1_index, src2_index, input src1_val, src2_val);
  modport PhysRegFile (input src1_index, src2_index, output src1_val, src2_val);
endinterface

// File: rtl/operand_bypass_mux.sv
// Per-source operand select: zero register, then same-cycle writeback, then register file.
module operand_bypass_mux
  import core_pkg::*;
(
  input  logic [PREG_W-1:0] preg,
  input  logic [XLEN-1:0]   prf_val,
  input  logic              wb_valid,
  input  logic [PREG_W-1:0] wb_preg,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   val
);

  always_comb begin
    val = prf_val;
    if (preg == PREG_ZERO) begin
      val = '0;
    end else if (wb_valid && (wb_preg == preg)) begin
      val = wb_data;
    end
  end

endmodule

// File: rtl/reg_read_stage.sv
// Register-read pipeline stage: reads two sources, applies writeback bypass,
// and registers operands plus payload behind a valid/ready handshake.
module reg_read_stage
  import core_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic [UOP_W-1:0]     in_uop,
  input  logic [PREG_W-1:0]    in_src1_preg,
  input  logic [PREG_W-1:0]    in_src2_preg,
  input  logic [PREG_W-1:0]    in_dest_preg,
  RegReadPhysRegFileIF.RegRead prf,
  input  logic                 wb_valid,
  input  logic [PREG_W-1:0]    wb_preg,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  output logic [UOP_W-1:0]     out_uop,
  output logic [PREG_W-1:0]    out_dest_preg,
  output logic [XLEN-1:0]      out_src1_val,
  output logic [XLEN-1:0]      out_src2_val
);

  logic              valid_q, valid_d;
  rr_payload_t       payload_q, payload_d;
  logic [XLEN-1:0]   src1_q, src1_d;
  logic [XLEN-1:0]   src2_q, src2_d;
  logic [XLEN-1:0]   src1_sel, src2_sel;
  logic              accept;

  assign prf.src1_index = in_src1_preg;
  assign prf.src2_index = in_src2_preg;

  operand_bypass_mux u_src1_mux (
    .preg     (in_src1_preg),
    .prf_val  (prf.src1_val),
    .wb_valid (wb_valid),
    .wb_preg  (wb_preg),
    .wb_data  (wb_data),
    .val      (src1_sel)
  );

  operand_bypass_mux u_src2_mux (
    .preg     (in_src2_preg),
    .prf_val  (prf.src2_val),
    .wb_valid (wb_valid),
    .wb_preg  (wb_preg),
    .wb_data  (wb_data),
    .val      (src2_sel)
  );

  // Ready depends only on register occupancy and downstream ready, never on in_valid
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next state: flush beats accept beats drain; data loads only on a real accept
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d             = 1'b1;
      payload_d.rob_idx   = in_rob_idx;
      payload_d.uop       = in_uop;
      payload_d.dest_preg = in_dest_preg;
      src1_d              = src1_sel;
      src2_d              = src2_sel;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_rob_idx   = payload_q.rob_idx;
  assign out_uop       = payload_q.uop;
  assign out_dest_preg = payload_q.dest_preg;
  assign out_src1_val  = src1_q;
  assign out_src2_val  = src2_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed self-checking bench for reg_read_stage with a small register-file model.
module tb_reg_read_stage;
  import core_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROB_IDX_W-1:0] in_rob_idx;
  logic [UOP_W-1:0]     in_uop;
  logic [PREG_W-1:0]    in_src1_preg;
  logic [PREG_W-1:0]    in_src2_preg;
  logic [PREG_W-1:0]    in_dest_preg;
  logic                 wb_valid;
  logic [PREG_W-1:0]    wb_preg;
  logic [XLEN-1:0]      wb_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [ROB_IDX_W-1:0] out_rob_idx;
  logic [UOP_W-1:0]     out_uop;
  logic [PREG_W-1:0]    out_dest_preg;
  logic [XLEN-1:0]      out_src1_val;
  logic [XLEN-1:0]      out_src2_val;

  logic [XLEN-1:0] prf_mem [NUM_PREGS];
  int unsigned n_checks;
  int unsigned n_fail;

  RegReadPhysRegFileIF prf_if ();

  // Register file model: combinational read, write commits at the edge
  assign prf_if.src1_val = prf_mem[prf_if.src1_index];
  assign prf_if.src2_val = prf_mem[prf_if.src2_index];
  always @(posedge clk) begin
    if (wb_valid && (wb_preg != PREG_ZERO)) prf_mem[wb_preg] <= wb_data;
  end

  reg_read_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rob_idx    (in_rob_idx),
    .in_uop        (in_uop),
    .in_src1_preg  (in_src1_preg),
    .in_src2_preg  (in_src2_preg),
    .in_dest_preg  (in_dest_preg),
    .prf           (prf_if.RegRead),
    .wb_valid      (wb_valid),
    .wb_preg       (wb_preg),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rob_idx   (out_rob_idx),
    .out_uop       (out_uop),
    .out_dest_preg (out_dest_preg),
    .out_src1_val  (out_src1_val),
    .out_src2_val  (out_src2_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int rob, input int src1, input int src2, input int dest);
    in_valid     = 1'b1;
    in_rob_idx   = ROB_IDX_W'(rob);
    in_uop       = 32'hC0DE_0000 + 32'(rob);
    in_src1_preg = PREG_W'(src1);
    in_src2_preg = PREG_W'(src2);
    in_dest_preg = PREG_W'(dest);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < int'(NUM_PREGS); k++) prf_mem[k] = 32'h1000 + 32'(k);
    prf_mem[0] = 32'h0;
    prf_mem[5] = 32'h11;
    prf_mem[9] = 32'h22;
    clk = 1'b0; rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_rob_idx = '0; in_uop = '0; in_src1_preg = '0; in_src2_preg = '0; in_dest_preg = '0;
    wb_valid = 1'b0; wb_preg = '0; wb_data = '0; out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_rob_idx", 32'(out_rob_idx), 32'd0);
    check("rst_uop", out_uop, 32'd0);
    check("rst_dest", 32'(out_dest_preg), 32'd0);
    check("rst_src1", out_src1_val, 32'd0);
    check("rst_src2", out_src2_val, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic read p5/p9
    issue(1, 5, 9, 3);
    step();
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_src1", out_src1_val, 32'h11);
    check("basic_src2", out_src2_val, 32'h22);
    check("basic_rob", 32'(out_rob_idx), 32'd1);
    check("basic_uop", out_uop, 32'hC0DE_0001);
    check("basic_dest", 32'(out_dest_preg), 32'd3);
    in_valid = 1'b0;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Writeback bypass on src2 while the register file still holds 0x22
    issue(2, 5, 9, 4);
    wb_valid = 1'b1; wb_preg = 6'd9; wb_data = 32'hABCD;
    step();
    check("byp_src1", out_src1_val, 32'h11);
    check("byp_src2", out_src2_val, 32'hABCD);

    // p0 stays zero even with a writeback naming p0
    issue(3, 0, 0, 0);
    wb_preg = 6'd0; wb_data = 32'hFFFF;
    step();
    check("p0_src1", out_src1_val, 32'h0);
    check("p0_src2", out_src2_val, 32'h0);
    wb_valid = 1'b0;

    // Both sources on the same register
    issue(4, 5, 5, 7);
    step();
    check("same_src1", out_src1_val, 32'h11);
    check("same_src2", out_src2_val, 32'h11);

    // Backpressure: hold rob 4 for 3 cycles with rob 5 waiting; a wb to p5 must not re-bypass
    out_ready = 1'b0;
    issue(5, 9, 0, 8);
    #1;
    check("stall_in_ready", 32'(in_ready), 32'd0);
    wb_valid = 1'b1; wb_preg = 6'd5; wb_data = 32'h77;
    for (int c = 0; c < 3; c++) begin
      step();
      wb_valid = 1'b0;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_rob", 32'(out_rob_idx), 32'd4);
      check("stall_src1", out_src1_val, 32'h11);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    step();
    check("release_valid", 32'(out_valid), 32'd1);
    check("release_rob", 32'(out_rob_idx), 32'd5);
    check("release_src1", out_src1_val, 32'hABCD);
    check("release_src2", out_src2_val, 32'h0);

    // Throughput: 8 back-to-back uops
    for (int i = 0; i < 8; i++) begin
      issue(i, 5, i + 10, i + 20);
      step();
      check("tput_valid", 32'(out_valid), 32'd1);
      check("tput_rob", 32'(out_rob_idx), 32'(i));
      check("tput_src1", out_src1_val, 32'h77);
      check("tput_src2", out_src2_val, 32'h1000 + 32'(i + 10));
    end
    in_valid = 1'b0;
    step();
    check("tput_drain", 32'(out_valid), 32'd0);

    // Flush drops both the held uop and the simultaneous accept
    issue(10, 5, 9, 1);
    step();
    check("preflush_valid", 32'(out_valid), 32'd1);
    issue(11, 5, 9, 2);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    step();
    check("postflush_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset during a stall
    issue(12, 5, 9, 1);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    check("prerst_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_rob", 32'(out_rob_idx), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("postrst_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
